// File: rtl/keystream_arbiter.sv
// Two-channel round-robin arbiter in front of a single hash byte generator, with rekey sequencing.
// Optional generator-answer timeout is enabled by defining KS_ARB_TIMEOUT_EN.
module keystream_arbiter #(
  parameter int REKEY_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       req_a_pulse,
  input  logic       req_b_pulse,
  input  logic       rekey,
  input  logic [7:0] hash_byte_in,
  input  logic       hash_byte_pulse_in,
  output logic       request_hash_byte_pulse,
  output logic       reset_hash,
  output logic [7:0] byte_a,
  output logic [7:0] byte_b,
  output logic       byte_a_valid,
  output logic       byte_b_valid,
  output logic       busy,
  output logic       req_overrun,
  output logic       timeout_err
);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_DELIVER, S_REKEY} state_e;

  localparam int RK_W = (REKEY_CYCLES > 1) ? $clog2(REKEY_CYCLES) : 1;

  state_e          state_q, state_d;
  logic            pend_a_q, pend_a_d, pend_b_q, pend_b_d;
  logic            last_b_q, last_b_d;
  logic            grant_b_q, grant_b_d;
  logic [7:0]      byte_a_q, byte_a_d, byte_b_q, byte_b_d;
  logic            ovr_q, ovr_d;
  logic [RK_W-1:0] rk_cnt_q, rk_cnt_d;
  logic            tmo_hit;
  logic            acc_a, acc_b, clr_a, clr_b;

`ifdef KS_ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt_q;
  logic            tmo_err_q;

  // Counts consecutive WAIT cycles; fires on the last allowed one without an answer.
  assign tmo_hit = (state_q == S_WAIT) && !hash_byte_pulse_in && !rekey &&
                   (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      to_cnt_q  <= '0;
      tmo_err_q <= 1'b0;
    end else begin
      to_cnt_q <= (state_q == S_WAIT) ? to_cnt_q + 1'b1 : '0;
      if (tmo_hit) tmo_err_q <= 1'b1;
    end
  end

  assign timeout_err = tmo_err_q;
`else
  assign tmo_hit     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // Requests are ignored in REKEY and when rekey is asserted; set beats the delivery clear.
  assign acc_a = req_a_pulse && (state_q != S_REKEY) && !rekey;
  assign acc_b = req_b_pulse && (state_q != S_REKEY) && !rekey;
  assign clr_a = (state_q == S_DELIVER) && !grant_b_q;
  assign clr_b = (state_q == S_DELIVER) &&  grant_b_q;

  always_comb begin
    state_d   = state_q;
    grant_b_d = grant_b_q;
    last_b_d  = last_b_q;
    byte_a_d  = byte_a_q;
    byte_b_d  = byte_b_q;
    rk_cnt_d  = rk_cnt_q;
    pend_a_d  = (pend_a_q && !clr_a) || acc_a;
    pend_b_d  = (pend_b_q && !clr_b) || acc_b;
    ovr_d     = ovr_q || (acc_a && pend_a_q && !clr_a) || (acc_b && pend_b_q && !clr_b);

    case (state_q)
      S_IDLE: begin
        if (pend_a_q || pend_b_q) begin
          state_d   = S_ISSUE;
          grant_b_d = pend_b_q && (!pend_a_q || !last_b_q);
        end
      end
      S_ISSUE, S_WAIT: begin
        if (hash_byte_pulse_in) begin
          state_d = S_DELIVER;
          if (grant_b_q) byte_b_d = hash_byte_in;
          else           byte_a_d = hash_byte_in;
        end else if (tmo_hit) begin
          state_d  = S_REKEY;
          rk_cnt_d = '0;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_DELIVER: begin
        state_d  = S_IDLE;
        last_b_d = grant_b_q;
      end
      S_REKEY: begin
        if (rk_cnt_q == RK_W'(REKEY_CYCLES - 1)) state_d = S_IDLE;
        else                                      rk_cnt_d = rk_cnt_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    // rekey overrides everything, including a byte arriving in the same cycle.
    if (rekey) begin
      state_d  = S_REKEY;
      rk_cnt_d = '0;
      pend_a_d = 1'b0;
      pend_b_d = 1'b0;
      byte_a_d = byte_a_q;
      byte_b_d = byte_b_q;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= S_IDLE;
      pend_a_q  <= 1'b0;
      pend_b_q  <= 1'b0;
      last_b_q  <= 1'b1;
      grant_b_q <= 1'b0;
      byte_a_q  <= 8'h00;
      byte_b_q  <= 8'h00;
      ovr_q     <= 1'b0;
      rk_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      pend_a_q  <= pend_a_d;
      pend_b_q  <= pend_b_d;
      last_b_q  <= last_b_d;
      grant_b_q <= grant_b_d;
      byte_a_q  <= byte_a_d;
      byte_b_q  <= byte_b_d;
      ovr_q     <= ovr_d;
      rk_cnt_q  <= rk_cnt_d;
    end
  end

  assign request_hash_byte_pulse = (state_q == S_ISSUE);
  assign reset_hash              = (state_q == S_REKEY);
  assign byte_a_valid            = (state_q == S_DELIVER) && !grant_b_q;
  assign byte_b_valid            = (state_q == S_DELIVER) &&  grant_b_q;
  assign busy                    = (state_q != S_IDLE);
  assign byte_a                  = byte_a_q;
  assign byte_b                  = byte_b_q;
  assign req_overrun             = ovr_q;

endmodule

// File: tb/tb_keystream_arbiter.sv
// Directed bench for keystream_arbiter; inputs change 1 time unit after each rising edge,
// outputs are checked at that point (they decode only registered state).
module tb_keystream_arbiter;

  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic       req_a_pulse = 1'b0, req_b_pulse = 1'b0, rekey = 1'b0;
  logic [7:0] hash_byte_in = 8'h00;
  logic       hash_byte_pulse_in = 1'b0;
  logic       request_hash_byte_pulse, reset_hash, byte_a_valid, byte_b_valid;
  logic       busy, req_overrun, timeout_err;
  logic [7:0] byte_a, byte_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  keystream_arbiter #(.REKEY_CYCLES(2), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .nrst(nrst),
    .req_a_pulse(req_a_pulse), .req_b_pulse(req_b_pulse), .rekey(rekey),
    .hash_byte_in(hash_byte_in), .hash_byte_pulse_in(hash_byte_pulse_in),
    .request_hash_byte_pulse(request_hash_byte_pulse), .reset_hash(reset_hash),
    .byte_a(byte_a), .byte_b(byte_b),
    .byte_a_valid(byte_a_valid), .byte_b_valid(byte_b_valid),
    .busy(busy), .req_overrun(req_overrun), .timeout_err(timeout_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rst();
    nrst = 1'b0;
    tick();
    tick();
    nrst = 1'b1;
    tick();
  endtask

  // Waits (bounded) for the ISSUE cycle, answers in the following cycle, checks delivery.
  task automatic serve(input string tag, input logic [7:0] b, input logic to_b);
    int n = 0;
    while (!request_hash_byte_pulse && n < 10) begin
      tick();
      n++;
    end
    chk({tag, "_issue"}, request_hash_byte_pulse, 8'd1);
    tick();
    hash_byte_in = b;
    hash_byte_pulse_in = 1'b1;
    tick();
    hash_byte_pulse_in = 1'b0;
    chk({tag, "_a_valid"}, byte_a_valid, to_b ? 8'd0 : 8'd1);
    chk({tag, "_b_valid"}, byte_b_valid, to_b ? 8'd1 : 8'd0);
    chk({tag, "_byte"}, to_b ? byte_b : byte_a, b);
    tick();
  endtask

  // Counts strobes over a window of cycles.
  task automatic window(input int n, output int ni, output int nv);
    ni = 0;
    nv = 0;
    for (int i = 0; i < n; i++) begin
      ni += int'(request_hash_byte_pulse);
      nv += int'(byte_a_valid) + int'(byte_b_valid);
      tick();
    end
  endtask

  initial begin
    int ni, nv;

    // Reset values
    rst();
    chk("rst_busy", busy, 8'd0);
    chk("rst_byte_a", byte_a, 8'h00);
    chk("rst_byte_b", byte_b, 8'h00);
    chk("rst_reset_hash", reset_hash, 8'd0);
    chk("rst_req", request_hash_byte_pulse, 8'd0);
    chk("rst_overrun", req_overrun, 8'd0);
    chk("rst_timeout", timeout_err, 8'd0);
    chk("rst_valids", {byte_a_valid, byte_b_valid}, 8'd0);

    // Single A request, answer in cycle 5
    req_a_pulse = 1'b1; tick(); req_a_pulse = 1'b0;           // c1
    chk("t1_c1_req", request_hash_byte_pulse, 8'd0);
    tick();                                                    // c2
    chk("t1_c2_req", request_hash_byte_pulse, 8'd1);
    chk("t1_c2_busy", busy, 8'd1);
    tick();                                                    // c3
    chk("t1_c3_req", request_hash_byte_pulse, 8'd0);
    tick(); tick();                                            // c5
    hash_byte_in = 8'h3C; hash_byte_pulse_in = 1'b1;
    tick(); hash_byte_pulse_in = 1'b0;                         // c6
    chk("t1_c6_a_valid", byte_a_valid, 8'd1);
    chk("t1_c6_byte_a", byte_a, 8'h3C);
    chk("t1_c6_b_valid", byte_b_valid, 8'd0);
    req_a_pulse = 1'b1;                                        // same cycle as the clear
    tick(); req_a_pulse = 1'b0;                                // c7
    chk("t1_c7_busy", busy, 8'd0);
    chk("t1_c7_a_valid", byte_a_valid, 8'd0);
    chk("t1_c7_byte_a_hold", byte_a, 8'h3C);
    chk("t1_c7_overrun", req_overrun, 8'd0);
    tick();                                                    // c8
    chk("t1_setwins_req", request_hash_byte_pulse, 8'd1);
    serve("t1_setwins", 8'h3D, 1'b0);

    // Simultaneous pairs: A first after reset, then B, and again A then B
    rst();
    req_a_pulse = 1'b1; req_b_pulse = 1'b1; tick();
    req_a_pulse = 1'b0; req_b_pulse = 1'b0;
    serve("t2_p1a", 8'h11, 1'b0);
    serve("t2_p1b", 8'h22, 1'b1);
    chk("t2_byte_a_hold", byte_a, 8'h11);
    req_a_pulse = 1'b1; req_b_pulse = 1'b1; tick();
    req_a_pulse = 1'b0; req_b_pulse = 1'b0;
    serve("t2_p2a", 8'h33, 1'b0);
    serve("t2_p2b", 8'h44, 1'b1);

    // Overrun: extra A pulses while A is pending
    rst();
    req_a_pulse = 1'b1; tick();                                // c1, pulse again
    chk("t3_c1_overrun", req_overrun, 8'd0);
    tick();                                                    // c2, pulse again
    chk("t3_c2_overrun", req_overrun, 8'd1);
    tick(); req_a_pulse = 1'b0;                                // c3 WAIT
    hash_byte_in = 8'h55; hash_byte_pulse_in = 1'b1;
    tick(); hash_byte_pulse_in = 1'b0;                         // c4 DELIVER
    chk("t3_a_valid", byte_a_valid, 8'd1);
    tick();
    window(8, ni, nv);
    chk("t3_no_reissue", 8'(ni), 8'd0);
    chk("t3_single_valid", 8'(nv), 8'd0);
    chk("t3_overrun_sticky", req_overrun, 8'd1);

    // Rekey during WAIT, generator answers one cycle later
    rst();
    req_b_pulse = 1'b1; tick(); req_b_pulse = 1'b0;            // c1
    tick();                                                    // c2
    chk("t4_issue", request_hash_byte_pulse, 8'd1);
    tick();                                                    // c3 WAIT
    rekey = 1'b1; tick(); rekey = 1'b0;                        // c4
    hash_byte_in = 8'h77; hash_byte_pulse_in = 1'b1;
    chk("t4_c4_reset_hash", reset_hash, 8'd1);
    tick(); hash_byte_pulse_in = 1'b0;                         // c5
    chk("t4_c5_reset_hash", reset_hash, 8'd1);
    chk("t4_c5_b_valid", byte_b_valid, 8'd0);
    tick();                                                    // c6
    chk("t4_c6_reset_hash", reset_hash, 8'd0);
    chk("t4_c6_busy", busy, 8'd0);
    chk("t4_c6_byte_b", byte_b, 8'h00);
    window(6, ni, nv);
    chk("t4_pend_cleared", 8'(ni), 8'd0);
    chk("t4_no_valid", 8'(nv), 8'd0);

    // Rekey re-asserted in REKEY restarts the count; requests in REKEY are dropped
    rekey = 1'b1; tick();                                      // c1 REKEY
    tick(); rekey = 1'b0;                                      // c2 REKEY restarted
    req_a_pulse = 1'b1;
    chk("t5_c2_reset_hash", reset_hash, 8'd1);
    tick(); req_a_pulse = 1'b0;                                // c3
    chk("t5_c3_reset_hash", reset_hash, 8'd1);
    tick();                                                    // c4
    chk("t5_c4_reset_hash", reset_hash, 8'd0);
    chk("t5_c4_busy", busy, 8'd0);
    window(5, ni, nv);
    chk("t5_req_dropped", 8'(ni), 8'd0);

    // Rekey and generator answer in the same WAIT cycle: rekey wins
    req_a_pulse = 1'b1; tick(); req_a_pulse = 1'b0;
    tick(); tick();                                            // c3 WAIT
    rekey = 1'b1; hash_byte_in = 8'h99; hash_byte_pulse_in = 1'b1;
    tick(); rekey = 1'b0; hash_byte_pulse_in = 1'b0;           // c4
    chk("t6_a_valid", byte_a_valid, 8'd0);
    chk("t6_reset_hash", reset_hash, 8'd1);
    chk("t6_byte_a", byte_a, 8'h00);
    tick(); tick();
    chk("t6_idle", busy, 8'd0);

    // Asynchronous reset mid-WAIT, then a fresh B request
    rst();
    req_b_pulse = 1'b1; tick(); req_b_pulse = 1'b0;
    serve("t7_pre", 8'h5A, 1'b1);
    req_a_pulse = 1'b1; tick(); tick(); req_a_pulse = 1'b0;    // overrun set
    tick();                                                    // c3 WAIT
    chk("t7_pre_overrun", req_overrun, 8'd1);
    #2 nrst = 1'b0;
    #1;
    chk("t7_async_busy", busy, 8'd0);
    chk("t7_async_byte_b", byte_b, 8'h00);
    chk("t7_async_overrun", req_overrun, 8'd0);
    chk("t7_async_strobes", {request_hash_byte_pulse, reset_hash, byte_a_valid, byte_b_valid}, 8'd0);
    tick();
    nrst = 1'b1; req_b_pulse = 1'b1;
    tick(); req_b_pulse = 1'b0;                                // c1
    chk("t7_c1_req", request_hash_byte_pulse, 8'd0);
    tick();                                                    // c2
    chk("t7_c2_req", request_hash_byte_pulse, 8'd1);

`ifdef KS_ARB_TIMEOUT_EN
    // No generator answer: timeout after 4 WAIT cycles
    rst();
    req_a_pulse = 1'b1; tick(); req_a_pulse = 1'b0;
    for (int i = 0; i < 5; i++) tick();                        // c6, last WAIT
    chk("t8_c6_timeout", timeout_err, 8'd0);
    chk("t8_c6_reset_hash", reset_hash, 8'd0);
    tick();                                                    // c7
    chk("t8_c7_timeout", timeout_err, 8'd1);
    chk("t8_c7_reset_hash", reset_hash, 8'd1);
    chk("t8_c7_a_valid", byte_a_valid, 8'd0);
    tick();                                                    // c8
    chk("t8_c8_reset_hash", reset_hash, 8'd1);
    tick();                                                    // c9
    chk("t8_c9_idle", busy, 8'd0);
    chk("t8_c9_timeout_sticky", timeout_err, 8'd1);
`else
    chk("t8_timeout_tied", timeout_err, 8'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/keystream_arbiter.md
KEYSTREAM_ARBITER -- requirements
Module: keystream_arbiter

Interface
REQ-001 The block SHALL have parameter REKEY_CYCLES, default 2, which is the number of cycles reset_hash is held high per rekey.
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 64, which is the maximum number of WAIT cycles (used only with KS_ARB_TIMEOUT_EN).
REQ-003 clk  input  1  clock; all state changes on its rising edge.
REQ-004 nrst  input  1  reset, asynchronous, active-low.
REQ-005 req_a_pulse / req_b_pulse  input  1 each  single-cycle byte request from channel A / B.
REQ-006 rekey  input  1  single-cycle request to restart the keystream.
REQ-007 hash_byte_in  input  8  byte from the hash generator.
REQ-008 hash_byte_pulse_in  input  1  hash generator byte-valid pulse.
REQ-009 request_hash_byte_pulse  output  1  single-cycle request to the hash generator.
REQ-010 reset_hash  output  1  synchronous restart of the hash generator.
REQ-011 byte_a / byte_b  output  8 each  last byte delivered to channel A / B.
REQ-012 byte_a_valid / byte_b_valid  output  1 each  single-cycle delivery strobe.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 req_overrun  output  1  sticky flag: a request arrived while the same channel was already pending.
REQ-015 timeout_err  output  1  sticky flag: the hash generator did not answer within TIMEOUT_CYCLES.

Function
REQ-016 The FSM SHALL have states IDLE, ISSUE, WAIT, DELIVER and REKEY.
REQ-017 Each channel SHALL have a pending flag, set at the clock edge that samples its request pulse.
REQ-018 A request pulse arriving while its pending flag is already set SHALL be dropped and SHALL set req_overrun.
REQ-019 A request pulse in the same cycle as the pending-clear for that channel SHALL leave the flag set (set wins).
REQ-020 IDLE SHALL go to ISSUE when any pending flag is set and rekey is low.
- The grant is latched on the IDLE-to-ISSUE edge, by round-robin over a last_grant pointer.
- After reset, last_grant = B, so A wins the first tie.
REQ-021 request_hash_byte_pulse SHALL be high exactly during the single ISSUE cycle, decoded from the state register; ISSUE then goes to WAIT.
- An isolated request pulse in cycle N SHALL therefore produce request_hash_byte_pulse in cycle N+2.
REQ-022 In ISSUE or WAIT, hash_byte_pulse_in high SHALL capture hash_byte_in into the granted channel's byte register and move to DELIVER.
- Pulses arriving in IDLE, DELIVER or REKEY SHALL be ignored.
REQ-023 DELIVER SHALL last one cycle and SHALL do the following, then go to IDLE:
- assert byte_x_valid for the granted channel;
- clear that channel's pending flag;
- set last_grant to the granted channel.
REQ-024 byte_a and byte_b SHALL hold their value until the next delivery to that same channel.
REQ-025 rekey high in any state SHALL, at the next edge:
- enter REKEY;
- clear both pending flags;
- abandon any grant with no valid strobe.
REQ-026 REKEY SHALL hold reset_hash high for exactly REKEY_CYCLES cycles, then go to IDLE; request pulses during REKEY SHALL be ignored.
- rekey asserted again while in REKEY SHALL restart the REKEY count.
REQ-027 rekey SHALL take priority over every other transition, including a simultaneous hash_byte_pulse_in.

Reset
REQ-028 On nrst low, all registers SHALL asynchronously reach the following values:
- state IDLE;
- pending flags 0;
- last_grant B;
- byte_a and byte_b 8'h00;
- all strobes, busy, reset_hash, req_overrun and timeout_err 0.
REQ-029 Reset SHALL need no clock edge to take effect; operation SHALL resume on the first edge after nrst rises.

Configuration
REQ-030 With KS_ARB_TIMEOUT_EN defined, the block SHALL count WAIT cycles.
- When the count reaches TIMEOUT_CYCLES, the block SHALL set timeout_err and enter REKEY.
- That request is dropped, with no valid strobe.
REQ-031 Without KS_ARB_TIMEOUT_EN, WAIT SHALL persist until hash_byte_pulse_in or rekey; timeout_err SHALL be tied 0 and TIMEOUT_CYCLES SHALL be unused.

Verification
REQ-032 req_a_pulse at cycle 0; generator answers 8'h3C at cycle 5 -> request_hash_byte_pulse at cycle 2, byte_a_valid at cycle 6 with byte_a = 8'h3C, busy low at cycle 7.
REQ-033 req_a_pulse and req_b_pulse both at cycle 0; answers 8'h11 then 8'h22 -> A is served 8'h11 first, then B is served 8'h22; a second simultaneous pair is served A then B again.
REQ-034 Two req_a_pulse pulses while A is pending and not yet delivered -> exactly one byte_a_valid and req_overrun = 1.
REQ-035 rekey during WAIT, then hash_byte_pulse_in one cycle later -> no valid strobe, reset_hash high for 2 cycles, pending flags 0, FSM back in IDLE.
REQ-036 With KS_ARB_TIMEOUT_EN, TIMEOUT_CYCLES = 4 and no generator answer -> timeout_err = 1 after 4 WAIT cycles, reset_hash pulses, no valid strobe.
REQ-037 nrst pulled low mid-WAIT -> all outputs reach their reset values immediately; a fresh req_b_pulse after release produces request_hash_byte_pulse 2 cycles later.
